// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the score display digit converter.
//   DIGIT_W      - default width of one published digit (renderer value port)
//   digit_t      - one published digit
//   bcd_state_e  - converter FSM states
//   bcd_nibbles  - number of BCD nibbles needed to hold a bin_w-bit value
package score_pkg;

  localparam int DIGIT_W = 12;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } bcd_state_e;

  // ceil(bin_w * log10(2)) using a fixed-point approximation of log10(2).
  function automatic int bcd_nibbles(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble step.
//   i_scratch  - NS BCD nibbles before the step
//   i_bit      - next binary bit (MSB first) shifted in at the bottom
//   o_scratch  - nibbles after add-3 correction and 1-bit left shift
//   o_carry    - bit shifted out of the top nibble (zero when NS is sized correctly)
module bcd_dabble_step #(
  parameter int NS = 5
) (
  input  logic [4*NS-1:0] i_scratch,
  input  logic            i_bit,
  output logic [4*NS-1:0] o_scratch,
  output logic            o_carry
);

  logic [4*NS-1:0] w_adj;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_nib
      // A nibble of 5..9 would become >=10 after doubling; pre-add 3 so the
      // shift carries into the next decade instead.
      assign w_adj[4*gi +: 4] = (i_scratch[4*gi +: 4] >= 4'd5) ?
                                (i_scratch[4*gi +: 4] + 4'd3) :
                                i_scratch[4*gi +: 4];
    end
  endgenerate

  assign {o_carry, o_scratch} = {w_adj, i_bit};

endmodule

// File: rtl/score_bcd_digits.sv
// score_bcd_digits: frame-synchronous binary to decimal digit converter.
// On each rising edge of i_v_sync (while idle) i_value is sampled and
// converted one bit per clock; the digits are published together at commit.
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_v_sync       - frame sync, rising edge triggers a conversion
//   i_value        - binary value, sampled at the trigger only
//   o_digit        - DIGITS slices of DIGIT_W bits, slice 0 = ones digit
//   o_digit_en     - per-digit significance (leading-zero blanking)
//   o_valid        - a conversion has committed since reset
//   o_busy         - conversion in progress
//   o_done         - one-cycle pulse after a commit
//   o_overflow     - last value did not fit in DIGITS digits (shown as all 9s)
module score_bcd_digits
  import score_pkg::*;
#(
  parameter int BIN_W   = 16,
  parameter int DIGITS  = 5,
  parameter int DIGIT_W = score_pkg::DIGIT_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_v_sync,
  input  logic [BIN_W-1:0]          i_value,
  output logic [DIGITS*DIGIT_W-1:0] o_digit,
  output logic [DIGITS-1:0]         o_digit_en,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow
);

  localparam int NS    = bcd_nibbles(BIN_W);
  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e                r_state;
  logic                      r_vs_q;
  logic [BIN_W-1:0]          r_shreg;
  logic [4*NS-1:0]           r_scratch;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_carry;
  logic [DIGITS*DIGIT_W-1:0] r_digit;
  logic [DIGITS-1:0]         r_digit_en;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_overflow;

  logic                      w_trigger;
  logic [4*NS-1:0]           w_scratch_next;
  logic                      w_carry;
  logic [3:0]                w_nib [DIGITS];
  logic [DIGITS-1:0]         w_any;
  logic [DIGITS-1:0]         w_en;
  logic [DIGITS*DIGIT_W-1:0] w_fmt;
  logic                      w_hi_nz;
  logic                      w_ovf;

  assign w_trigger = i_v_sync & ~r_vs_q;

  bcd_dabble_step #(.NS(NS)) u_step (
    .i_scratch (r_scratch),
    .i_bit     (r_shreg[BIN_W-1]),
    .o_scratch (w_scratch_next),
    .o_carry   (w_carry)
  );

  // Output formatting from the finished scratch; only sampled in COMMIT.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi < NS) begin : g_src
        assign w_nib[gi] = r_scratch[4*gi +: 4];
      end else begin : g_pad
        assign w_nib[gi] = 4'd0;
      end

      // w_any[k]: some digit at index >= k is nonzero.
      if (gi == DIGITS - 1) begin : g_top
        assign w_any[gi] = |w_nib[gi];
      end else begin : g_chain
        assign w_any[gi] = (|w_nib[gi]) | w_any[gi+1];
      end

      assign w_en[gi] = w_any[gi] | (gi == 0);
      assign w_fmt[gi*DIGIT_W +: DIGIT_W] = w_ovf ? DIGIT_W'(9) : DIGIT_W'(w_nib[gi]);
    end

    if (NS > DIGITS) begin : g_hi
      assign w_hi_nz = |r_scratch[4*NS-1:4*DIGITS];
    end else begin : g_no_hi
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  // The carry term only matters if NS were ever undersized; it keeps the
  // overflow flag truthful in that case.
  assign w_ovf = w_hi_nz | r_carry;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_vs_q     <= 1'b0;
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_digit    <= '0;
      r_digit_en <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_vs_q <= i_v_sync;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_shreg   <= i_value;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(BIN_W);
            r_carry   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shreg   <= r_shreg << 1;
          r_carry   <= r_carry | w_carry;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_digit    <= w_fmt;
          r_digit_en <= w_ovf ? '1 : w_en;
          r_overflow <= w_ovf;
          r_valid    <= 1'b1;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_digit    = r_digit;
  assign o_digit_en = r_digit_en;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_digits.sv
// tb_score_bcd_digits: two converter instances (5 digits and 3 digits) share
// one stimulus stream; a cycle-level behavioural model computes the expected
// outputs with plain decimal arithmetic and is compared every cycle.
module tb_score_bcd_digits;

  localparam int BW = 16;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst;
  logic vs;
  logic [BW-1:0] val;

  logic [5*DW-1:0] a_digit;
  logic [4:0]      a_en;
  logic            a_valid, a_busy, a_done, a_ovf;
  logic [3*DW-1:0] b_digit;
  logic [2:0]      b_en;
  logic            b_valid, b_busy, b_done, b_ovf;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  score_bcd_digits #(.BIN_W(BW), .DIGITS(5), .DIGIT_W(DW)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_v_sync(vs), .i_value(val),
    .o_digit(a_digit), .o_digit_en(a_en), .o_valid(a_valid),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf)
  );

  score_bcd_digits #(.BIN_W(BW), .DIGITS(3), .DIGIT_W(DW)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_v_sync(vs), .i_value(val),
    .o_digit(b_digit), .o_digit_en(b_en), .o_valid(b_valid),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int j = 0; j < e; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [5*DW-1:0] pack5(input int d4, input int d3, input int d2,
                                            input int d1, input int d0);
    return {DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  function automatic logic [3*DW-1:0] pack3(input int d2, input int d1, input int d0);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // ---------------- behavioural model ----------------
  int          m_cnt   [2];
  int unsigned m_val   [2];
  bit          m_prev  [2];
  bit          m_busy  [2];
  bit          m_valid [2];
  bit          m_done  [2];
  bit          m_ovf   [2];
  int          m_en    [2];
  int          m_dig   [2][5];

  function automatic int ndig(input int i);
    return (i == 0) ? 5 : 3;
  endfunction

  function automatic void model_commit(input int i);
    int nd = ndig(i);
    int v  = int'(m_val[i]);
    m_busy[i]  = 1'b0;
    m_valid[i] = 1'b1;
    m_done[i]  = 1'b1;
    m_en[i]    = 0;
    if (v > pow10(nd) - 1) begin
      m_ovf[i] = 1'b1;
      for (int k = 0; k < nd; k++) m_dig[i][k] = 9;
      m_en[i] = (1 << nd) - 1;
    end else begin
      m_ovf[i] = 1'b0;
      for (int k = 0; k < nd; k++) begin
        m_dig[i][k] = (v / pow10(k)) % 10;
        if (k == 0 || v >= pow10(k)) m_en[i] = m_en[i] | (1 << k);
      end
    end
    $display("txn inst=%0d digits=%0d value=%0d overflow=%0d", i, nd, v, m_ovf[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_prev[i] = 1'b0; m_busy[i] = 1'b0; m_valid[i] = 1'b0;
        m_done[i] = 1'b0; m_ovf[i] = 1'b0; m_en[i] = 0;
        for (int k = 0; k < 5; k++) m_dig[i][k] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) model_commit(i);
        end else if (vs && !m_prev[i]) begin
          m_val[i]  = val;
          m_cnt[i]  = BW + 1;
          m_busy[i] = 1'b1;
        end
        m_prev[i] = vs;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("a_busy",  64'(a_busy),  64'(m_busy[0]));
    chk("a_valid", 64'(a_valid), 64'(m_valid[0]));
    chk("a_done",  64'(a_done),  64'(m_done[0]));
    chk("a_ovf",   64'(a_ovf),   64'(m_ovf[0]));
    chk("a_en",    64'(a_en),    64'(m_en[0]));
    for (int k = 0; k < 5; k++) chk("a_digit", 64'(a_digit[k*DW +: DW]), 64'(m_dig[0][k]));
    chk("b_busy",  64'(b_busy),  64'(m_busy[1]));
    chk("b_valid", 64'(b_valid), 64'(m_valid[1]));
    chk("b_done",  64'(b_done),  64'(m_done[1]));
    chk("b_ovf",   64'(b_ovf),   64'(m_ovf[1]));
    chk("b_en",    64'(b_en),    64'(m_en[1]));
    for (int k = 0; k < 3; k++) chk("b_digit", 64'(b_digit[k*DW +: DW]), 64'(m_dig[1][k]));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Trigger one conversion; returns edges from trigger to commit (-1 on timeout).
  task automatic convert(input int v, output int lat);
    vs = 1'b0;
    tick();
    vs  = 1'b1;
    val = BW'(v);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        vs  = 1'b0;
        val = BW'($urandom);
      end
      if (a_done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [5*DW-1:0] got;

    rst = 1'b1; vs = 1'b0; val = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vs = ~vs;
    end
    vs = 1'b0;
    tick();
    chk("rst_digit", 64'(a_digit), 64'(0));
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_done",  64'(a_done),  64'(0));
    rst = 1'b0;
    tick();

    convert(0, lat);
    chk("zero_latency", 64'(lat), 64'(17));
    chk("zero_digits",  64'(a_digit), 64'(pack5(0, 0, 0, 0, 0)));
    chk("zero_en",      64'(a_en), 64'(5'b00001));
    chk("zero_valid",   64'(a_valid), 64'(1));
    tick();
    chk("zero_done_width", 64'(a_done), 64'(0));

    convert(65535, lat);
    chk("max_digits", 64'(a_digit), 64'(pack5(6, 5, 5, 3, 5)));
    chk("max_en",     64'(a_en), 64'(5'b11111));
    chk("max_ovf",    64'(a_ovf), 64'(0));

    convert(1209, lat);
    chk("interior_digits", 64'(a_digit), 64'(pack5(0, 1, 2, 0, 9)));
    chk("interior_en",     64'(a_en), 64'(5'b01111));

    convert(1234, lat);
    chk("ovf3_digits", 64'(b_digit), 64'(pack3(9, 9, 9)));
    chk("ovf3_en",     64'(b_en), 64'(3'b111));
    chk("ovf3_flag",   64'(b_ovf), 64'(1));

    convert(42, lat);
    chk("ok3_digits", 64'(b_digit), 64'(pack3(0, 4, 2)));
    chk("ok3_flag",   64'(b_ovf), 64'(0));
    chk("ok3_en",     64'(b_en), 64'(3'b011));

    // Second v_sync rise and a new value mid-conversion must be ignored;
    // v_sync then stays high and must not retrigger.
    vs = 1'b0; tick();
    vs = 1'b1; val = BW'(500); ndone = 0; got = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) vs = 1'b0;
      if (k == 4) begin vs = 1'b1; val = BW'(7); end
      if (a_done) begin ndone++; got = a_digit; end
    end
    chk("dist_digits",     64'(got), 64'(pack5(0, 0, 5, 0, 0)));
    chk("dist_done_count", 64'(ndone), 64'(1));

    // Reset mid-conversion abandons it.
    vs = 1'b0; tick();
    vs = 1'b1; val = BW'(777); ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) vs = 1'b0;
      if (k == 7) rst = 1'b1;
      if (k == 8) rst = 1'b0;
      if (a_done) ndone++;
    end
    chk("rstmid_done_count", 64'(ndone), 64'(0));
    chk("rstmid_valid",      64'(a_valid), 64'(0));
    chk("rstmid_digit",      64'(a_digit), 64'(0));
    chk("rstmid_en",         64'(a_en), 64'(0));

    // Trigger coinciding with reset: reset wins.
    vs = 1'b1; val = BW'(123); rst = 1'b1;
    tick();
    rst = 1'b0; vs = 1'b0;
    tick();
    chk("rst_trig_busy", 64'(a_busy), 64'(0));

    // Randomized traffic with boundary values and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      case ($urandom_range(0, 3))
        0: val = BW'($urandom);
        1: val = BW'($urandom_range(0, 1100));
        2: begin
          int pick[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 65535};
          val = BW'(pick[$urandom_range(0, 9)]);
        end
        default: val = BW'($urandom_range(0, 99999) % 65536);
      endcase
    end
    rst = 1'b0; vs = 1'b0;
    repeat (25) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_bcd_digits.md
# score_bcd_digits

Frame-synchronous binary-to-decimal converter for the on-screen score/counter display. Once per frame, on the rising edge of `i_v_sync`, it samples a binary value and converts it with an iterative double-dabble (shift-and-add-3) engine, one bit per clock. It then publishes one 12-bit digit value per display position, plus leading-zero enables. Each digit output drives the `value` input of one 8x4-cell digit sprite renderer, so a `DIGITS`-wide score is `DIGITS` renderers fed by this block.

## Interface
Parameters:
- `BIN_W`, 16, width of the binary input value.
- `DIGITS`, 5, number of decimal digits published. Must be ≥1.
- `DIGIT_W`, 12, width of each published digit; matches the renderer `value` port.

Ports:
- `i_clk` in 1: single system/pixel clock; everything is on its rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_v_sync` in 1: frame sync. Its rising edge is the conversion trigger.
- `i_value` in `BIN_W`: binary value to display, sampled only at the trigger.
- `o_digit` out `DIGITS*DIGIT_W`: flat packed digits. Slice k, bits `[k*DIGIT_W +: DIGIT_W]`, is the 10^k digit (slice 0 = ones). Each slice is in 0..9, zero-extended.
- `o_digit_en` out `DIGITS`: bit k high when digit k is significant (not a leading zero). Bit 0 is always 1 once valid.
- `o_valid` out 1: high once at least one conversion has committed since reset.
- `o_busy` out 1: high while a conversion is in progress.
- `o_done` out 1: one-cycle pulse in the cycle after a commit.
- `o_overflow` out 1: last committed value exceeded 10^DIGITS − 1.

## Operation
- **Edge detect**
  - A registered copy of `i_v_sync` is held in `vs_q`.
  - trigger = `i_v_sync & ~vs_q`.
- **FSM states:** IDLE, SHIFT, COMMIT.
  - **IDLE** + trigger → SHIFT.
    - Latch `i_value` into the shift register.
    - Clear the BCD scratch.
    - Set the bit counter to `BIN_W`.
    - Raise `o_busy`.
  - **SHIFT**, one step per cycle:
    - Add 3 to every scratch nibble that is ≥5.
    - Shift {scratch, shreg} left by one.
    - Decrement the counter.
    - When the counter reaches 1, the step executes and the next state is COMMIT.
  - **COMMIT**:
    - Register the outputs.
    - Set `o_valid`.
    - Pulse `o_done` next cycle.
    - Drop `o_busy`.
    - Return to IDLE.
- **Scratch width:** NS = ceil(BIN_W·log10 2) nibbles (5 for 16 bits), independent of `DIGITS`.
- **Overflow:** any scratch nibble at index ≥ `DIGITS` is nonzero. Then:
  - All `o_digit` slices = 9.
  - `o_digit_en` = all ones.
  - `o_overflow` = 1.
  - Otherwise `o_overflow` = 0.
- **Leading zeros:** `o_digit_en[k]` = 1 iff k = 0 or some digit at index ≥ k is nonzero. Interior zeros stay enabled.
- **Triggers outside IDLE** (SHIFT/COMMIT) are ignored, not queued.
- **Input stability:** `i_value` changes after the trigger edge do not affect the result.
- **Output stability:** outputs change only at COMMIT. They hold their old value through the whole conversion, so the renderers never see a half-converted digit.
- **Reset values:** all `o_digit` slices 0, `o_digit_en` 0, `o_valid` 0, `o_busy` 0, `o_done` 0, `o_overflow` 0, state IDLE, `vs_q` 0.
- **Reset mid-conversion:** the conversion is abandoned with no commit, and all outputs go to their reset values.
- **Trigger coinciding with reset:** reset wins.

## Timing
- Trigger sampled at edge t: state = SHIFT and `o_busy` = 1 after t.
- SHIFT steps occur at edges t+1 … t+`BIN_W`.
- Outputs update at edge t+`BIN_W`+1. `o_busy` falls at the same edge.
- `o_done` is high for exactly the cycle following edge t+`BIN_W`+1.
- Latency trigger→outputs: `BIN_W`+1 cycles (17 by default).
- A new trigger is accepted from edge t+`BIN_W`+2 onward.
- `i_v_sync` held high does not retrigger; only a rising edge triggers.

## Structure
- **Shared package `score_pkg`:**
  - `DIGIT_W` default.
  - Typedef `digit_t` (`logic [DIGIT_W-1:0]`).
  - FSM state enum `bcd_state_e`.
  - Constant function `bcd_nibbles(bin_w)` returning NS.
- **Sub-module `bcd_dabble_step`:**
  - Combinational.
  - Parameterised by NS.
  - Performs one add-3 correction plus the 1-bit left shift of {scratch, incoming bit}.
  - Instantiated once; the top owns the registers, counter, FSM and output formatting.

## Test plan
- **Reset:** assert `i_rst` 3 cycles with `i_v_sync` toggling → all outputs 0, no `o_done`.
- **Zero:** `i_value`=0, rising `i_v_sync` → 17 cycles later digits {4..0} = 0,0,0,0,0, `o_digit_en`=5'b00001, `o_done` pulse of 1 cycle, `o_valid`=1.
- **Maximum:** `i_value`=65535 → digits 6,5,5,3,5, `o_digit_en`=5'b11111, `o_overflow`=0.
- **Interior zero:** `i_value`=1209 → digits 0,1,2,0,9, `o_digit_en`=5'b01111.
- **Overflow:** `DIGITS`=3, `i_value`=1234 → digits 9,9,9, `o_digit_en`=3'b111, `o_overflow`=1. Then `i_value`=42 → 0,4,2, `o_overflow`=0.
- **Disturbance:** trigger with 500, then a second `i_v_sync` rise and `i_value`=7 at cycle 5 → result 5,0,0 at cycle 17 and no second `o_done`. Separately, `i_rst` at cycle 8 → no commit, all outputs 0.
